// File: rtl/tile_wb_arbiter.sv
// Tile write-back arbiter: grants one requester's result tile and streams it word by word
// into a single memory write port. Define TILE_WB_FIXED_PRIO_EN for fixed-priority arbitration.
module tile_wb_arbiter #(
  parameter int DATA_W     = 16,
  parameter int ARRAY_SIZE = 2,
  parameter int N_REQ      = 2,
  parameter int ADDR_W     = 10
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic [N_REQ-1:0]                            req_valid,
  output logic [N_REQ-1:0]                            req_ready,
  input  logic [N_REQ*ARRAY_SIZE*ARRAY_SIZE*DATA_W-1:0] req_data,
  input  logic [N_REQ*ADDR_W-1:0]                     req_base,
  output logic                                        mem_we,
  output logic [ADDR_W-1:0]                           mem_addr,
  output logic [DATA_W-1:0]                           mem_wdata,
  input  logic                                        mem_ready,
  output logic                                        busy,
  output logic                                        done,
  output logic [$clog2(N_REQ)-1:0]                    done_id
);

  localparam int E      = ARRAY_SIZE * ARRAY_SIZE;
  localparam int TILE_W = E * DATA_W;
  localparam int ID_W   = $clog2(N_REQ);
  localparam int IDX_W  = (E > 1) ? $clog2(E) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(E - 1);
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(N_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [ID_W-1:0]     win_q, win_d;
  logic [ID_W-1:0]     done_id_q, done_id_d;
  logic [TILE_W-1:0]   tile_q, tile_d;
  logic [ADDR_W-1:0]   base_q, base_d;

  logic [N_REQ-1:0]    grant;
  logic [ID_W-1:0]     grant_id;
  logic                grant_any;
  logic [ID_W-1:0]     rr_start;

`ifdef TILE_WB_FIXED_PRIO_EN
  assign rr_start = '0;
`else
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  assign rr_start = rr_ptr_q;
`endif

  // Two passes give a wrapping search: indices at/after the pointer first, then the rest.
  always_comb begin
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (req_valid[i] && !grant_any && (ID_W'(i) >= rr_start)) begin
        grant[i]  = 1'b1;
        grant_id  = ID_W'(i);
        grant_any = 1'b1;
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (req_valid[i] && !grant_any && (ID_W'(i) < rr_start)) begin
        grant[i]  = 1'b1;
        grant_id  = ID_W'(i);
        grant_any = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    win_d     = win_q;
    done_id_d = done_id_q;
    tile_d    = tile_q;
    base_d    = base_q;
`ifndef TILE_WB_FIXED_PRIO_EN
    rr_ptr_d  = rr_ptr_q;
`endif
    req_ready = '0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    busy      = 1'b0;
    done      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // Gated by rst_n so no transfer can be signalled while reset is asserted.
        req_ready = rst_n ? grant : '0;
        if (grant_any) begin
          for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
              tile_d = req_data[i*TILE_W +: TILE_W];
              base_d = req_base[i*ADDR_W +: ADDR_W];
            end
          end
          win_d   = grant_id;
          idx_d   = '0;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        busy     = 1'b1;
        mem_we   = 1'b1;
        mem_addr = base_q + ADDR_W'(idx_q);
        for (int i = 0; i < E; i++) begin
          if (idx_q == IDX_W'(i)) mem_wdata = tile_q[i*DATA_W +: DATA_W];
        end
        if (mem_ready) begin
          if (idx_q == LAST_IDX) begin
            idx_d     = '0;
            done_id_d = win_q;
            state_d   = S_DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
`ifndef TILE_WB_FIXED_PRIO_EN
        rr_ptr_d = (win_q == LAST_ID) ? '0 : win_q + 1'b1;
`endif
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign done_id = done_id_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      win_q     <= '0;
      done_id_q <= '0;
`ifndef TILE_WB_FIXED_PRIO_EN
      rr_ptr_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      win_q     <= win_d;
      done_id_q <= done_id_d;
`ifndef TILE_WB_FIXED_PRIO_EN
      rr_ptr_q  <= rr_ptr_d;
`endif
    end
  end

  // Tile payload is only observed in WRITE, so it needs no reset.
  always_ff @(posedge clk) begin
    tile_q <= tile_d;
    base_q <= base_d;
  end

endmodule

// File: tb/tb_tile_wb_arbiter.sv
// Directed bench for tile_wb_arbiter: a per-cycle vector table plus sequences for
// round-robin ordering and reset during a tile.
module tb_tile_wb_arbiter;

  localparam int DATA_W = 16;
  localparam int ARRAY_SIZE = 2;
  localparam int N_REQ = 2;
  localparam int ADDR_W = 10;
  localparam int E = 4;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [N_REQ-1:0]          req_valid;
  logic [N_REQ-1:0]          req_ready;
  logic [N_REQ*E*DATA_W-1:0] req_data;
  logic [N_REQ*ADDR_W-1:0]   req_base;
  logic                      mem_we;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_wdata;
  logic                      mem_ready;
  logic                      busy;
  logic                      done;
  logic [0:0]                done_id;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  tile_wb_arbiter #(
    .DATA_W(DATA_W), .ARRAY_SIZE(ARRAY_SIZE), .N_REQ(N_REQ), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_base(req_base),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready),
    .busy(busy), .done(done), .done_id(done_id)
  );

  typedef struct packed {
    logic [1:0]  v;
    logic        mr;
    logic [1:0]  rdy;
    logic        we;
    logic [9:0]  addr;
    logic [15:0] wd;
    logic        bsy;
    logic        dn;
    logic        id;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] v, input logic mr, input logic [1:0] rdy,
                              input logic we, input logic [9:0] addr, input logic [15:0] wd,
                              input logic bsy, input logic dn, input logic id);
    vec_t r;
    r.v = v; r.mr = mr; r.rdy = rdy; r.we = we; r.addr = addr; r.wd = wd;
    r.bsy = bsy; r.dn = dn; r.id = id;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input vec_t e);
    chk({nm, ".ready"}, req_ready, e.rdy);
    chk({nm, ".we"},    mem_we,    e.we);
    chk({nm, ".addr"},  mem_addr,  e.addr);
    chk({nm, ".wdata"}, mem_wdata, e.wd);
    chk({nm, ".busy"},  busy,      e.bsy);
    chk({nm, ".done"},  done,      e.dn);
    chk({nm, ".id"},    done_id,   e.id);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req_valid = '0; mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_done(input string nm);
    bit seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk); #1;
      if (done) seen = 1'b1;
    end
    chk(nm, seen, 1);
  endtask

  vec_t tbl[24];

  initial begin
    rst_n = 1'b0;
    req_valid = '0;
    mem_ready = 1'b1;
    req_data = {64'h0008_0007_0006_0005, 64'h0004_0003_0002_0001};
    req_base = {10'h3FE, 10'h010};

    // Reset values
    @(negedge clk); #1;
    chk_all("reset", mk(2'b00, 1, 2'b00, 0, 10'h000, 16'h0000, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;

`ifndef TILE_WB_FIXED_PRIO_EN
    tbl[0]  = mk(2'b00, 1, 2'b00, 0, 10'h000, 16'h0000, 0, 0, 0);
    tbl[1]  = mk(2'b01, 1, 2'b01, 0, 10'h000, 16'h0000, 0, 0, 0);
    tbl[2]  = mk(2'b00, 1, 2'b00, 1, 10'h010, 16'h0001, 1, 0, 0);
    tbl[3]  = mk(2'b00, 1, 2'b00, 1, 10'h011, 16'h0002, 1, 0, 0);
    tbl[4]  = mk(2'b00, 1, 2'b00, 1, 10'h012, 16'h0003, 1, 0, 0);
    tbl[5]  = mk(2'b00, 1, 2'b00, 1, 10'h013, 16'h0004, 1, 0, 0);
    tbl[6]  = mk(2'b00, 1, 2'b00, 0, 10'h000, 16'h0000, 1, 1, 0);
    tbl[7]  = mk(2'b11, 1, 2'b10, 0, 10'h000, 16'h0000, 0, 0, 0);
    tbl[8]  = mk(2'b00, 0, 2'b00, 1, 10'h3FE, 16'h0005, 1, 0, 0);
    tbl[9]  = mk(2'b00, 1, 2'b00, 1, 10'h3FE, 16'h0005, 1, 0, 0);
    tbl[10] = mk(2'b00, 0, 2'b00, 1, 10'h3FF, 16'h0006, 1, 0, 0);
    tbl[11] = mk(2'b00, 0, 2'b00, 1, 10'h3FF, 16'h0006, 1, 0, 0);
    tbl[12] = mk(2'b00, 1, 2'b00, 1, 10'h3FF, 16'h0006, 1, 0, 0);
    tbl[13] = mk(2'b00, 1, 2'b00, 1, 10'h000, 16'h0007, 1, 0, 0);
    tbl[14] = mk(2'b00, 0, 2'b00, 1, 10'h001, 16'h0008, 1, 0, 0);
    tbl[15] = mk(2'b00, 1, 2'b00, 1, 10'h001, 16'h0008, 1, 0, 0);
    tbl[16] = mk(2'b00, 1, 2'b00, 0, 10'h000, 16'h0000, 1, 1, 1);
    tbl[17] = mk(2'b11, 1, 2'b01, 0, 10'h000, 16'h0000, 0, 0, 1);
    tbl[18] = mk(2'b10, 1, 2'b00, 1, 10'h010, 16'h0001, 1, 0, 1);
    tbl[19] = mk(2'b10, 1, 2'b00, 1, 10'h011, 16'h0002, 1, 0, 1);
    tbl[20] = mk(2'b10, 1, 2'b00, 1, 10'h012, 16'h0003, 1, 0, 1);
    tbl[21] = mk(2'b10, 1, 2'b00, 1, 10'h013, 16'h0004, 1, 0, 1);
    tbl[22] = mk(2'b10, 1, 2'b00, 0, 10'h000, 16'h0000, 1, 1, 0);
    tbl[23] = mk(2'b10, 1, 2'b10, 0, 10'h000, 16'h0000, 0, 0, 0);

    for (int r = 0; r < 24; r++) begin
      @(negedge clk);
      req_valid = tbl[r].v;
      mem_ready = tbl[r].mr;
      #1;
      chk_all($sformatf("row%0d", r), tbl[r]);
    end
`endif

    // Both requesters held valid: grant order and spacing
    begin
      int gr[$];
      int last_c;
      int we_cnt;
      do_reset();
      req_valid = 2'b11;
      last_c = 0;
      we_cnt = 0;
      for (int c = 0; c < 60 && gr.size() < 4; c++) begin
        #1;
        if (req_ready != 2'b00) begin
          if (gr.size() > 0) begin
            chk($sformatf("rr_words%0d", gr.size()), we_cnt, E);
            chk($sformatf("rr_gap%0d", gr.size()), c - last_c, E + 2);
          end
          gr.push_back((req_ready == 2'b10) ? 1 : 0);
          last_c = c;
          we_cnt = 0;
        end
        if (mem_we) we_cnt++;
        @(negedge clk);
      end
      req_valid = 2'b00;
      chk("rr_grant_count", gr.size(), 4);
      for (int k = 0; k < gr.size(); k++) begin
`ifdef TILE_WB_FIXED_PRIO_EN
        chk($sformatf("prio_grant%0d", k), gr[k], 0);
`else
        chk($sformatf("rr_grant%0d", k), gr[k], k % 2);
`endif
      end
    end

    // Reset in the middle of a tile from req1, after req0 moved the pointer
    do_reset();
    req_valid = 2'b01;
    #1 chk("mid_grant0", req_ready, 2'b01);
    @(negedge clk);
    req_valid = 2'b00;
    wait_done("mid_first_done");
    @(negedge clk);
    req_valid = 2'b10;
    #1 chk("mid_grant1", req_ready, 2'b10);
    @(negedge clk);
    req_valid = 2'b00;
    #1 chk("mid_w1_addr", mem_addr, 10'h3FE);
    @(negedge clk); #1;
    chk("mid_w2_addr", mem_addr, 10'h3FF);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk_all("mid_rst", mk(2'b00, 1, 2'b00, 0, 10'h000, 16'h0000, 0, 0, 0));
    repeat (3) begin
      @(negedge clk); #1;
      chk("mid_rst_we", mem_we, 0);
      chk("mid_rst_done", done, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 2'b11;
    #1 chk("mid_post_grant", req_ready, 2'b01);
    @(negedge clk);
    req_valid = 2'b00;
    wait_done("mid_post_done");
    chk("mid_post_id", done_id, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
